arith_cmp_arbiter: RTL and testbench

ARITH_CMP_ARBITER -- requirements
Module: arith_cmp_arbiter

---
 rtl/arith_cmp_arbiter.sv | 146 ++++++++++++++
 tb/tb_arith_cmp_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_cmp_arbiter.sv
// Two-requester round-robin arbiter feeding a single add/sub/compare unit.
// One operation in flight at a time: IDLE accepts, EXEC computes, DONE holds the response.
module arith_cmp_arbiter #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [1:0]   req0_op,
  input  logic [1:0]   req1_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic         rsp_equal,
  output logic         rsp_less,
  output logic         rsp_greater,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e       state_q, state_d;
  logic         last_grant_q;
  logic         grant;
  logic         accept;
  logic [N-1:0] a_q, b_q;
  logic [1:0]   op_q;
  logic         id_q;

  logic [N-1:0] result_d, result_q;
  logic         equal_d, less_d, greater_d;
  logic         equal_q, less_q, greater_q;
  logic         rsp_valid_q, rsp_id_q;

  // Under contention the requester that did not win last time is favoured.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      StIdle: begin
        req0_ready = req0_valid & ~grant;
        req1_ready = req1_valid & grant;
        accept     = (req0_valid & ~grant) | (req1_valid & grant);
        if (accept) begin
          state_d = StExec;
        end
      end
      StExec: state_d = StDone;
      StDone: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    result_d  = '0;
    equal_d   = 1'b0;
    less_d    = 1'b0;
    greater_d = 1'b0;
    unique case (op_q)
      2'b00: result_d = a_q + b_q;
      2'b01: result_d = a_q - b_q;
      2'b10: begin
        equal_d   = (a_q == b_q);
        less_d    = (a_q < b_q);
        greater_d = (a_q > b_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant_q <= grant;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 2'b11;
      id_q        <= 1'b0;
      result_q    <= '0;
      equal_q     <= 1'b0;
      less_q      <= 1'b0;
      greater_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
    end else begin
      if (accept) begin
        a_q  <= grant ? req1_a  : req0_a;
        b_q  <= grant ? req1_b  : req0_b;
        op_q <= grant ? req1_op : req0_op;
        id_q <= grant;
      end
      if (state_q == StExec) begin
        result_q    <= result_d;
        equal_q     <= equal_d;
        less_q      <= less_d;
        greater_q   <= greater_d;
        rsp_id_q    <= id_q;
        rsp_valid_q <= 1'b1;
      end else if (state_q == StDone && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_result  = result_q;
  assign rsp_equal   = equal_q;
  assign rsp_less    = less_q;
  assign rsp_greater = greater_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_arith_cmp_arbiter.sv
// Scoreboard bench for arith_cmp_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_arith_cmp_arbiter;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0]   req0_op = 2'b00, req1_op = 2'b00;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic         rsp_id;
  logic [N-1:0] rsp_result;
  logic         rsp_equal, rsp_less, rsp_greater;
  logic         busy;

  arith_cmp_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_equal  (rsp_equal),
    .rsp_less   (rsp_less),
    .rsp_greater(rsp_greater),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       id;
    logic [7:0] res;
    logic       eq;
    logic       lt;
    logic       gt;
  } exp_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic       id;
    logic [7:0] r;
    logic       eq;
    logic       lt;
    logic       gt;
  } vec_t;

  exp_t exp_q[$];
  int   hs_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   hs_count = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: scoreboard pop on handshake, accept-to-valid latency, mutual exclusion of readies.
  int   acc_cyc = 0;
  bit   acc_pending = 0;
  logic prev_v = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    if (!rst_n) begin
      acc_pending = 0;
      prev_v      = 1'b0;
    end else begin
      chk("ready_exclusive", {31'd0, req0_ready & req1_ready}, 32'd0);
      if (rsp_valid && !prev_v && acc_pending) begin
        chk("latency", cyc - acc_cyc, 2);
        acc_pending = 0;
      end
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        acc_cyc     = cyc;
        acc_pending = 1;
      end
      prev_v = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp", {20'd0, rsp_id, rsp_result, rsp_equal, rsp_less, rsp_greater}, {20'd0, e});
        end
        hs_count++;
        hs_cyc.push_back(cyc);
      end
    end
  end

  task automatic wait_hs(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (hs_count >= target) break;
    end
    chk("hs_timeout", hs_count, target);
    #1;
  endtask

  task automatic drop_and_scramble();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = 8'hA5; req0_b = 8'h5A; req0_op = 2'b01;
    req1_a = 8'hC3; req1_b = 8'h3C; req1_op = 2'b00;
  endtask

  task automatic issue(input vec_t v);
    int target;
    bit ok;
    exp_q.push_back('{id: v.id, res: v.r, eq: v.eq, lt: v.lt, gt: v.gt});
    target = hs_count + 1;
    @(posedge clk); #1;
    if (v.id == 1'b0) begin
      req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_op = v.op;
    end else begin
      req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_op = v.op;
    end
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((v.id == 1'b0 && req0_ready) || (v.id == 1'b1 && req1_ready)) begin
        ok = 1;
        break;
      end
    end
    chk("accept_timeout", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    drop_and_scramble();
    wait_hs(target, 20);
  endtask

  // Both requesters valid with fixed operands until n more responses have completed.
  task automatic run_both(input int n);
    int target;
    target = hs_count + n;
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02; req0_op = 2'b00;
    req1_valid = 1'b1; req1_a = 8'h09; req1_b = 8'h04; req1_op = 2'b01;
    wait_hs(target, 3 * n + 10);
    drop_and_scramble();
  endtask

  vec_t vecs [9] = '{
    '{a: 8'h06, b: 8'h05, op: 2'b00, id: 1'b0, r: 8'h0B, eq: 1'b0, lt: 1'b0, gt: 1'b0},
    '{a: 8'h06, b: 8'h05, op: 2'b01, id: 1'b0, r: 8'h01, eq: 1'b0, lt: 1'b0, gt: 1'b0},
    '{a: 8'h06, b: 8'h05, op: 2'b10, id: 1'b0, r: 8'h00, eq: 1'b0, lt: 1'b0, gt: 1'b1},
    '{a: 8'hFF, b: 8'h01, op: 2'b00, id: 1'b1, r: 8'h00, eq: 1'b0, lt: 1'b0, gt: 1'b0},
    '{a: 8'h00, b: 8'h01, op: 2'b01, id: 1'b1, r: 8'hFF, eq: 1'b0, lt: 1'b0, gt: 1'b0},
    '{a: 8'h3C, b: 8'h3C, op: 2'b10, id: 1'b0, r: 8'h00, eq: 1'b1, lt: 1'b0, gt: 1'b0},
    '{a: 8'h10, b: 8'h20, op: 2'b10, id: 1'b1, r: 8'h00, eq: 1'b0, lt: 1'b1, gt: 1'b0},
    '{a: 8'h80, b: 8'h7F, op: 2'b01, id: 1'b0, r: 8'h01, eq: 1'b0, lt: 1'b0, gt: 1'b0},
    '{a: 8'hC8, b: 8'h64, op: 2'b00, id: 1'b1, r: 8'h2C, eq: 1'b0, lt: 1'b0, gt: 1'b0}
  };

  initial begin
    bit   seen_v;
    vec_t bp;

    // Reset state, with both requesters already waiting.
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02; req0_op = 2'b00;
    req1_valid = 1'b1; req1_a = 8'h09; req1_b = 8'h04; req1_op = 2'b01;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {25'd0, rsp_valid, rsp_id, rsp_equal, rsp_less, rsp_greater, busy, 1'b0},
        32'd0);
    chk("reset_result", {24'd0, rsp_result}, 32'd0);

    // Continuous contention from reset: 0,1,0,1 with one response every 3 cycles.
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{id: 1'b0, res: 8'h03, eq: 1'b0, lt: 1'b0, gt: 1'b0});
      exp_q.push_back('{id: 1'b1, res: 8'h05, eq: 1'b0, lt: 1'b0, gt: 1'b0});
    end
    hs_cyc.delete();
    rst_n = 1'b1;
    #1;
    chk("first_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    run_both(4);
    if (hs_cyc.size() == 4) begin
      for (int i = 0; i < 3; i++) chk("rsp_spacing", hs_cyc[i+1] - hs_cyc[i], 3);
    end else begin
      chk("rsp_count", hs_cyc.size(), 4);
    end

    foreach (vecs[i]) issue(vecs[i]);

    // Backpressure: hold the response for 5 cycles while requester 1 waits.
    bp = '{a: 8'h20, b: 8'h22, op: 2'b00, id: 1'b0, r: 8'h42, eq: 1'b0, lt: 1'b0, gt: 1'b0};
    rsp_ready = 1'b0;
    exp_q.push_back('{id: 1'b0, res: 8'h42, eq: 1'b0, lt: 1'b0, gt: 1'b0});
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = bp.a; req0_b = bp.b; req0_op = bp.op;
    @(posedge clk); #1;
    drop_and_scramble();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    req1_valid = 1'b1; req1_a = 8'h11; req1_b = 8'h22; req1_op = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {21'd0, rsp_valid, busy, req0_ready, req1_ready, rsp_result}, {21'd0, 4'b1100, 8'h42});
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("hs_cycle_no_accept", {30'd0, req0_ready, req1_ready}, 32'd0);
    wait_hs(hs_count + 1, 5);
    req1_valid = 1'b0;
    @(negedge clk);
    chk("rsp_valid_drop", {30'd0, rsp_valid, busy}, 32'd0);

    // Reset during EXEC: requester 0 accepted, so without reset it would lose the next contention.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 8'h33; req0_b = 8'h11; req0_op = 2'b01;
    @(posedge clk); #2;
    drop_and_scramble();
    chk("in_exec", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {25'd0, rsp_valid, rsp_id, rsp_equal, rsp_less, rsp_greater, busy,
        req0_ready | req1_ready}, 32'd0);
    chk("async_reset_result", {24'd0, rsp_result}, 32'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    seen_v = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) seen_v = 1;
    end
    chk("no_rsp_after_reset", {31'd0, seen_v}, 32'd0);
    exp_q.push_back('{id: 1'b0, res: 8'h03, eq: 1'b0, lt: 1'b0, gt: 1'b0});
    @(posedge clk); #1;
    run_both(1);

    // No-op from requester 1 still completes a full handshake.
    issue('{a: 8'h12, b: 8'h34, op: 2'b11, id: 1'b1, r: 8'h00, eq: 1'b0, lt: 1'b0, gt: 1'b0});

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
